// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: the instruction-memory request/response channel and
// the ID-side valid/ready handshake. The master is the fetch unit; the slave
// side is the memory plus the decode stage.
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;
  logic            id_pred_taken;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_valid, id_instr, id_pc, id_pc4, id_pred_taken,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_instr, id_pc, id_pc4, id_pred_taken,
    output id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: PC generation (redirect > prediction > PC+4),
// in-order memory requests tracked by an in-flight PC queue, and a fetch queue
// feeding ID. A redirect flushes both queues and arms a drop counter so that
// responses to requests issued before the redirect are silently discarded.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] bp_lookup_pc,
  input  logic            bp_hit,
  input  logic            bp_taken,
  input  logic [XLEN-1:0] bp_pred_pc,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  fetch_unit_if.master    bus
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;

  typedef logic [XLEN-1:0] word_t;

  word_t          pc_q, pc_d;
  // in-flight queue: PC and prediction of each live outstanding request
  word_t          ifq_pc_q   [FQ_DEPTH], ifq_pc_d   [FQ_DEPTH];
  logic           ifq_pred_q [FQ_DEPTH], ifq_pred_d [FQ_DEPTH];
  logic [AW-1:0]  ifq_wr_q, ifq_wr_d, ifq_rd_q, ifq_rd_d;
  // fetch queue toward ID
  word_t          fq_instr_q [FQ_DEPTH], fq_instr_d [FQ_DEPTH];
  word_t          fq_pc_q    [FQ_DEPTH], fq_pc_d    [FQ_DEPTH];
  word_t          fq_pc4_q   [FQ_DEPTH], fq_pc4_d   [FQ_DEPTH];
  logic           fq_pred_q  [FQ_DEPTH], fq_pred_d  [FQ_DEPTH];
  logic [AW-1:0]  fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
  logic [CW-1:0]  fq_cnt_q, fq_cnt_d;
  logic [CW-1:0]  out_q, out_d;    // all outstanding requests, stale included
  logic [CW-1:0]  drop_q, drop_d;  // responses still to be discarded

  logic           pred, acc, pop, rsp, push;
  logic [OW-1:0]  occ;
  logic           unused;

  assign unused = ex_target[0];
  assign pred   = bp_hit & bp_taken;
  assign rsp    = bus.imem_rsp_valid;
  assign occ    = {1'b0, fq_cnt_q} + {1'b0, out_q};

  assign bp_lookup_pc      = pc_q;
  assign bus.imem_addr     = pc_q;
  // rst gates the request so it drops immediately when reset asserts
  assign bus.imem_req_valid = rst && !ex_redirect && (occ < OW'(FQ_DEPTH));
  assign bus.id_valid      = (fq_cnt_q != '0) && !ex_redirect;
  assign bus.id_instr      = fq_instr_q[fq_rd_q];
  assign bus.id_pc         = fq_pc_q[fq_rd_q];
  assign bus.id_pc4        = fq_pc4_q[fq_rd_q];
  assign bus.id_pred_taken = fq_pred_q[fq_rd_q];

  assign acc = bus.imem_req_valid & bus.imem_req_ready;
  assign pop = bus.id_valid & bus.id_ready;

  // next-state: PC selection, queue pushes/pops, counters, redirect flush
  always_comb begin
    pc_d       = pc_q;
    ifq_pc_d   = ifq_pc_q;
    ifq_pred_d = ifq_pred_q;
    ifq_wr_d   = ifq_wr_q;
    ifq_rd_d   = ifq_rd_q;
    fq_instr_d = fq_instr_q;
    fq_pc_d    = fq_pc_q;
    fq_pc4_d   = fq_pc4_q;
    fq_pred_d  = fq_pred_q;
    fq_wr_d    = fq_wr_q;
    fq_rd_d    = fq_rd_q;
    fq_cnt_d   = fq_cnt_q;
    drop_d     = drop_q;
    push       = 1'b0;
    // acc is already forced low during a redirect
    out_d      = out_q + CW'(acc) - CW'(rsp);

    if (ex_redirect) begin
      pc_d     = {ex_target[XLEN-1:1], 1'b0};
      ifq_wr_d = '0;
      ifq_rd_d = '0;
      fq_wr_d  = '0;
      fq_rd_d  = '0;
      fq_cnt_d = '0;
      // everything still in flight after this cycle is stale
      drop_d   = out_q - CW'(rsp);
    end else begin
      if (acc) begin
        ifq_pc_d[ifq_wr_q]   = pc_q;
        ifq_pred_d[ifq_wr_q] = pred;
        ifq_wr_d             = ifq_wr_q + AW'(1);
        pc_d                 = pred ? bp_pred_pc : pc_q + word_t'(4);
      end
      if (rsp) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          push                = 1'b1;
          fq_instr_d[fq_wr_q] = bus.imem_rsp_data;
          fq_pc_d[fq_wr_q]    = ifq_pc_q[ifq_rd_q];
          fq_pc4_d[fq_wr_q]   = ifq_pc_q[ifq_rd_q] + word_t'(4);
          fq_pred_d[fq_wr_q]  = ifq_pred_q[ifq_rd_q];
          fq_wr_d             = fq_wr_q + AW'(1);
          ifq_rd_d            = ifq_rd_q + AW'(1);
        end
      end
      if (pop) fq_rd_d = fq_rd_q + AW'(1);
      fq_cnt_d = fq_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // state registers; storage cleared too so head fields read zero after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      ifq_wr_q <= '0;
      ifq_rd_q <= '0;
      fq_wr_q  <= '0;
      fq_rd_q  <= '0;
      fq_cnt_q <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        ifq_pc_q[i]   <= '0;
        ifq_pred_q[i] <= 1'b0;
        fq_instr_q[i] <= '0;
        fq_pc_q[i]    <= '0;
        fq_pc4_q[i]   <= '0;
        fq_pred_q[i]  <= 1'b0;
      end
    end else begin
      pc_q       <= pc_d;
      ifq_pc_q   <= ifq_pc_d;
      ifq_pred_q <= ifq_pred_d;
      ifq_wr_q   <= ifq_wr_d;
      ifq_rd_q   <= ifq_rd_d;
      fq_instr_q <= fq_instr_d;
      fq_pc_q    <= fq_pc_d;
      fq_pc4_q   <= fq_pc4_d;
      fq_pred_q  <= fq_pred_d;
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
      fq_cnt_q   <= fq_cnt_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit. The reference model tracks the architectural
// stream: which PC must be requested next, the list of live fetched PCs in
// program order, how many have arrived from memory, and which memory requests
// are stale because a redirect happened after they were issued.
module tb_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bp_lookup_pc, bp_pred_pc, ex_target;
  logic        bp_hit, bp_taken, ex_redirect;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bp_lookup_pc(bp_lookup_pc), .bp_hit(bp_hit),
    .bp_taken(bp_taken), .bp_pred_pc(bp_pred_pc), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  typedef struct { logic [31:0] addr; bit stale; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit pred; } fent_t;

  mreq_t       mem_q[$];
  fent_t       live_q[$];
  int          n_arr;
  logic [31:0] exp_pc;
  int          cyc = 0;
  int          p_rdy, p_idr, p_redir, p_bp, p_rsp, max_lat;

  task automatic model_reset();
    mem_q.delete();
    live_q.delete();
    n_arr  = 0;
    exp_pc = RPC;
  endtask

  task automatic neutral_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;
    bp_hit = 1'b0; bp_taken = 1'b0; bp_pred_pc = '0;
    ex_redirect = 1'b0; ex_target = '0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_id_valid",  bus.id_valid, 0);
    chk("rst_imem_addr", bus.imem_addr, RPC);
    chk("rst_bp_lookup", bp_lookup_pc, RPC);
    chk("rst_id_instr",  bus.id_instr, 0);
    chk("rst_id_pc",     bus.id_pc, 0);
    chk("rst_id_pc4",    bus.id_pc4, 0);
    chk("rst_id_pred",   bus.id_pred_taken, 0);
  endtask

  task automatic run(input int n);
    bit rsp, stale, acc, pop, exp_rv, exp_iv, tk;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cyc++;
      rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < p_rsp);
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
      bus.imem_req_ready = $urandom_range(99) < p_rdy;
      bus.id_ready       = $urandom_range(99) < p_idr;
      bp_hit      = $urandom_range(99) < p_bp;
      bp_taken    = $urandom_range(1) == 1;
      bp_pred_pc  = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'd3);
      ex_redirect = $urandom_range(99) < p_redir;
      ex_target   = ($urandom_range(2) == 0) ? 32'hFFFF_FFFD : $urandom;
      #4;
      exp_rv = !ex_redirect && (n_arr + mem_q.size() < DEPTH);
      exp_iv = (n_arr > 0) && !ex_redirect;
      chk("req_valid", bus.imem_req_valid, exp_rv);
      chk("imem_addr", bus.imem_addr, exp_pc);
      chk("bp_lookup_pc", bp_lookup_pc, exp_pc);
      chk("id_valid", bus.id_valid, exp_iv);
      if (exp_iv) begin
        chk("id_pc",    bus.id_pc, live_q[0].pc);
        chk("id_pc4",   bus.id_pc4, live_q[0].pc + 32'd4);
        chk("id_instr", bus.id_instr, mem_word(live_q[0].pc));
        chk("id_pred",  bus.id_pred_taken, live_q[0].pred);
      end
      // advance the model by the events of the coming edge
      acc   = exp_rv && bus.imem_req_ready;
      pop   = exp_iv && bus.id_ready;
      tk    = bp_hit && bp_taken;
      stale = 1'b0;
      if (rsp) begin
        stale = mem_q[0].stale;
        void'(mem_q.pop_front());
      end
      if (ex_redirect) begin
        live_q.delete();
        n_arr = 0;
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        exp_pc = {ex_target[31:1], 1'b0};
      end else begin
        if (pop) begin
          void'(live_q.pop_front());
          n_arr--;
        end
        if (rsp && !stale) n_arr++;
        if (acc) begin
          mem_q.push_back('{addr: exp_pc, stale: 1'b0, due: cyc + $urandom_range(max_lat, 1)});
          live_q.push_back('{pc: exp_pc, pred: tk});
          exp_pc = tk ? bp_pred_pc : exp_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    neutral_inputs();
    model_reset();
    #12;
    chk_reset_outputs();
    #10 rst = 1'b1;

    // zero-wait memory, ID always ready: 2-cycle fill then 1 instr/cycle
    p_rdy = 100; p_idr = 100; p_redir = 0; p_bp = 0; p_rsp = 100; max_lat = 1;
    run(12);
    // ID stalled: exactly FQ_DEPTH requests, then drain in order
    p_idr = 0;
    run(8);
    p_idr = 100;
    run(8);
    // predictions, variable latency, back-pressure, redirects
    p_rdy = 75; p_idr = 70; p_redir = 6; p_bp = 30; p_rsp = 70; max_lat = 4;
    run(3000);

    // asynchronous reset in the middle of fetching
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk_reset_outputs();
    neutral_inputs();
    model_reset();
    #2 rst = 1'b1;
    run(1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
